melody_sequencer: RTL and testbench

- Sits directly upstream of the buzzer tone generator.
- Debounces the raw play button and runs a play/pause state machine.
- Steps through a packed song of 4-bit note codes, one code per beat: 0..6 = do..si, 4'hF = rest.
- Presents the current code plus a note_on qualifier to the tone generator, so the tone stage no longer needs its own lyric shifting.

---
 rtl/melody_pkg.sv | 27 ++
 rtl/button_debouncer.sv | 50 +++++
 rtl/melody_sequencer.sv | 133 +++++++++++++
 tb/tb_melody_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared note codes, sequencer state type and default song for the melody sequencer.
package melody_pkg;

  localparam logic [3:0] NOTE_DO   = 4'h0;
  localparam logic [3:0] NOTE_RE   = 4'h1;
  localparam logic [3:0] NOTE_MI   = 4'h2;
  localparam logic [3:0] NOTE_FA   = 4'h3;
  localparam logic [3:0] NOTE_SO   = 4'h4;
  localparam logic [3:0] NOTE_LA   = 4'h5;
  localparam logic [3:0] NOTE_SI   = 4'h6;
  localparam logic [3:0] NOTE_REST = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Nibble [3:0] plays first.
  localparam logic [127:0] DEFAULT_SONG = 128'hffff0261354760225411022546103332;

  // Codes 7..E carry no pitch and are played as rests.
  function automatic logic is_note(input logic [3:0] code);
    return code <= NOTE_SI;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, hold-time debounce counter and rising-edge press pulse
// for a raw asynchronous push button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    // Any cycle where the synced input agrees with the accepted level restarts the hold time.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/melody_sequencer.sv
// Play/pause song sequencer feeding the buzzer tone generator with one note code per beat.
// Build option: define MELODY_SEQUENCER_LOOP_EN to loop the song instead of stopping at its end.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_FRE         = 100000000,
  parameter int BEAT_CYCLES     = 25000000,
  parameter int GAP_CYCLES      = 2500000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SONG_LEN        = 32,
  parameter logic [4*SONG_LEN-1:0] SONG = (4*SONG_LEN)'(DEFAULT_SONG)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_play,
  output logic [3:0] note_code,
  output logic       note_on,
  output logic       beat_tick,
  output logic       playing,
  output logic       song_done
);

  // CLK_FRE only documents the clock rate; a non-positive value collapses beats to one cycle.
  localparam int BEAT_LEN = (CLK_FRE > 0) ? BEAT_CYCLES : 1;
  localparam int CNT_W    = (BEAT_LEN > 1) ? $clog2(BEAT_LEN) : 1;
  localparam int IDX_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BEAT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(SONG_LEN - 1);
  localparam logic [31:0]      SOUND_CYCLES = 32'(BEAT_LEN - GAP_CYCLES);

  logic [3:0] song_mem [SONG_LEN];

  for (genvar gi = 0; gi < SONG_LEN; gi++) begin : g_song
    assign song_mem[gi] = SONG[4*gi +: 4];
  end

  logic press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_play),
    .press_o(press)
  );

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             beat_end, last_beat;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_cnt_d = beat_cnt_q;
    beat_end   = (state_q == PLAY) && (beat_cnt_q == CNT_LAST);
    last_beat  = beat_end && (idx_q == IDX_LAST);

    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d    = PLAY;
          beat_cnt_d = '0;
        end
      end
      PLAY: begin
        if (beat_end) begin
          beat_cnt_d = '0;
          idx_d      = last_beat ? '0 : idx_q + 1'b1;
        end else if (!press) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (last_beat) begin
`ifdef MELODY_SEQUENCER_LOOP_EN
          if (press) state_d = PAUSE;
`else
          // The end of the song takes priority over a coincident press.
          state_d = IDLE;
`endif
        end else if (press) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (press) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0] raw_code;
  logic       sounding;
  logic [3:0] note_code_q, note_code_d;
  logic       note_on_q, note_on_d;
  logic       beat_tick_q, playing_q, song_done_q;

  always_comb begin
    raw_code    = song_mem[idx_q];
    sounding    = (state_q == PLAY) && (32'(beat_cnt_q) < SOUND_CYCLES);
    note_on_d   = sounding && is_note(raw_code);
    note_code_d = note_on_d ? raw_code : NOTE_REST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      beat_cnt_q  <= '0;
      note_code_q <= NOTE_REST;
      note_on_q   <= 1'b0;
      beat_tick_q <= 1'b0;
      playing_q   <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      beat_cnt_q  <= beat_cnt_d;
      note_code_q <= note_code_d;
      note_on_q   <= note_on_d;
      beat_tick_q <= (state_q == PLAY) && (beat_cnt_q == '0);
      playing_q   <= (state_q == PLAY);
      song_done_q <= last_beat;
    end
  end

  assign note_code = note_code_q;
  assign note_on   = note_on_q;
  assign beat_tick = beat_tick_q;
  assign playing   = playing_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: stimulus queues expected beat outputs, a monitor checks them.
module tb_melody_sequencer;

  localparam int BEAT = 8;
  localparam int GAP  = 2;
  localparam int DEB  = 4;
  localparam int LEN  = 4;
  localparam logic [15:0] SONG_P = 16'hF210;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_play;
  logic [3:0] note_code;
  logic       note_on, beat_tick, playing, song_done;

  always #5 clk = ~clk;

  melody_sequencer #(
    .CLK_FRE        (100000000),
    .BEAT_CYCLES    (BEAT),
    .GAP_CYCLES     (GAP),
    .DEBOUNCE_CYCLES(DEB),
    .SONG_LEN       (LEN),
    .SONG           (SONG_P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_play (btn_play),
    .note_code(note_code),
    .note_on  (note_on),
    .beat_tick(beat_tick),
    .playing  (playing),
    .song_done(song_done)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       tick;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_play_cyc = -1;
  int   done_cnt = 0;

  // Hand-derived song codes for 16'hF210: do, re, mi, rest.
  logic [3:0] song_tab [LEN] = '{4'h0, 4'h1, 4'h2, 4'hF};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (song_done === 1'b1) done_cnt++;
    if (playing === 1'b1) begin
      if (first_play_cyc < 0) first_play_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_play: cyc=%0d code=%h with no expected beat output queued", cyc, note_code);
      end else begin
        mon_e = exp_q.pop_front();
        $display("beat_out cyc=%0d code=%h on=%0b tick=%0b done=%0b", cyc, note_code, note_on, beat_tick, song_done);
        if ({note_code, note_on, beat_tick, song_done} !==
            {mon_e.code, (mon_e.code != 4'hF), mon_e.tick, mon_e.done}) begin
          errors++;
          $display("FAIL play_out: cyc=%0d got code=%h on=%0b tick=%0b done=%0b expected code=%h on=%0b tick=%0b done=%0b",
                   cyc, note_code, note_on, beat_tick, song_done,
                   mon_e.code, (mon_e.code != 4'hF), mon_e.tick, mon_e.done);
        end
      end
    end else begin
      checks++;
      if (note_code !== 4'hF || note_on !== 1'b0 || beat_tick !== 1'b0 || song_done !== 1'b0 || playing !== 1'b0) begin
        errors++;
        $display("FAIL idle_out: cyc=%0d got code=%h on=%0b tick=%0b done=%0b play=%0b expected code=f on=0 tick=0 done=0 play=0",
                 cyc, note_code, note_on, beat_tick, song_done, playing);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Clean press: high for 5 edges, then released (release settles well before the next press).
  task automatic press_btn();
    btn_play = 1'b1;
    tick(5);
    btn_play = 1'b0;
  endtask

  task automatic push_beat(input logic [3:0] code, input int from, input int to, input bit last);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.code = (c < BEAT - GAP) ? code : 4'hF;
      e.tick = (c == 0);
      e.done = last && (c == BEAT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_song();
    for (int b = 0; b < LEN; b++) push_beat(song_tab[b], 0, BEAT - 1, b == LEN - 1);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected beat outputs never appeared", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int t0;
    int done_base;
    rst      = 1'b1;
    btn_play = 1'b0;
    tick(3);
    check("reset_code", 32'(note_code), 32'hF);
    check("reset_flags", 32'({note_on, beat_tick, playing, song_done}), 32'h0);
    rst = 1'b0;
    tick(2);

`ifndef MELODY_SEQUENCER_LOOP_EN
    // 1: one clean press plays the whole song once, then stops.
    first_play_cyc = -1;
    done_base = done_cnt;
    push_song();
    t0 = cyc;
    press_btn();
    wait_drain("song", 200);
    tick(10);
    check("t1_latency", 32'(first_play_cyc - t0), 32'd8);
    check("t1_done_count", 32'(done_cnt - done_base), 32'd1);
    check("t1_stopped", 32'(playing), 32'd0);

    // 2: bouncing button produces exactly one press.
    first_play_cyc = -1;
    done_base = done_cnt;
    push_song();
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      btn_play = ((i % 4) < 2);
      if (i == 8) t0 = cyc;
      tick(1);
    end
    tick(3);
    btn_play = 1'b0;
    wait_drain("bounce", 200);
    tick(10);
    check("t2_latency", 32'(first_play_cyc - t0), 32'd8);
    check("t2_done_count", 32'(done_cnt - done_base), 32'd1);

    // 3: pause at beat 1 / beat_cnt 3, resume 20 cycles later.
    done_base = done_cnt;
    push_beat(4'h0, 0, 7, 1'b0);
    push_beat(4'h1, 0, 3, 1'b0);
    push_beat(4'h1, 3, 7, 1'b0);
    push_beat(4'h2, 0, 7, 1'b0);
    push_beat(4'hF, 0, 7, 1'b1);
    press_btn();
    tick(7);
    press_btn();
    tick(15);
    press_btn();
    wait_drain("pause", 200);
    tick(10);
    check("t3_done_count", 32'(done_cnt - done_base), 32'd1);

    // 4: reset in the middle of beat 2, then a fresh press restarts at do.
    push_beat(4'h0, 0, 7, 1'b0);
    push_beat(4'h1, 0, 7, 1'b0);
    push_beat(4'h2, 0, 2, 1'b0);
    press_btn();
    tick(21);
    rst = 1'b1;
    tick(1);
    check("t4_rst_code", 32'(note_code), 32'hF);
    check("t4_rst_playing", 32'(playing), 32'd0);
    check("t4_rst_queue", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    tick(2);
    push_song();
    press_btn();
    wait_drain("restart", 200);
    tick(10);

    // 5: press lands exactly on the last beat end; song end wins.
    done_base = done_cnt;
    push_song();
    press_btn();
    tick(27);
    press_btn();
    wait_drain("end_press", 200);
    tick(20);
    check("t5_done_count", 32'(done_cnt - done_base), 32'd1);
    check("t5_idle", 32'(playing), 32'd0);
    push_song();
    press_btn();
    wait_drain("after_end", 200);
    tick(10);
`else
    // 6: looping build; three passes, then a press on the final beat end pauses at idx 0.
    done_base = done_cnt;
    push_song();
    push_song();
    push_song();
    press_btn();
    tick(91);
    press_btn();
    wait_drain("loop", 400);
    tick(10);
    check("t6_done_count", 32'(done_cnt - done_base), 32'd3);
    check("t6_paused", 32'(playing), 32'd0);
    push_beat(4'h0, 0, 7, 1'b0);
    press_btn();
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_resume_queue", 32'(exp_q.size()), 32'd0);
    check("t6_rst_playing", 32'(playing), 32'd0);
    exp_q.delete();
    tick(5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
